uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `tx` with configurable data width, runtime-selectable parity and 1 or 2 stop bits. Frames are emitted back-to-back with no idle gap while the FIFO holds data. It sits between the decoder's byte-producing logic and the board UART pin, driven by the shared baud tick generator (one-cycle pulse per bit period, no oversampling).

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, range 2..256.

Ports:
- `clk_in` input, 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n_in` input, 1: asynchronous active-low reset.
- `baud_tick` input, 1: one-cycle strobe marking each bit-period boundary.
- `data_in` input, `DATA_W`: byte to enqueue.
- `valid_in` input, 1: `data_in` valid.
- `ready_out` output, 1: FIFO can accept; a push occurs when `valid_in && ready_out`.
- `parity_mode_in` input, 2: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `two_stop_in` input, 1: 0 = one stop bit, 1 = two stop bits.
- `tx` output, 1: serial line, idle high.
- `tx_busy` output, 1: a frame is in progress.
- `fifo_count_out` output, `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.

## Operation
- Reset (async assert, sync deassert handled upstream): `tx`=1, `tx_busy`=0, `ready_out`=1, `fifo_count_out`=0, FSM in IDLE, FIFO pointers 0.
- FIFO: `ready_out` = (count != FIFO_DEPTH), derived from registered count. Push with a simultaneous pop keeps count unchanged. A word pushed in cycle N is poppable in cycle N+1 at the earliest. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. On `baud_tick` with count>0, pop the head word and latch it together with `parity_mode_in` and `two_stop_in` (config is frozen for the frame). Go to START; `tx`=0 and `tx_busy`=1 from the next cycle.
  - START: on `baud_tick`, go to DATA with bit index 0 and drive `data[0]`.
  - DATA: on each `baud_tick`, advance the index and drive `data[idx]`. After bit `DATA_W-1` has held for one period, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: drive the parity bit for one period. Even mode = XOR of data bits; odd mode = XNOR of data bits.
  - STOP: `tx`=1 for 1 or 2 periods. At the closing `baud_tick`:
    - if count>0, pop and go directly to START (`tx`=0 next cycle, `tx_busy` stays 1);
    - otherwise go to IDLE with `tx_busy`=0.
- Frame length is 1 + DATA_W + P + S bit periods, where P ∈ {0,1} and S ∈ {1,2}.
- Changes to config inputs mid-frame have no effect until the next pop.
- `baud_tick` asserted on the same cycle as a push to an empty FIFO does not start a frame; the next tick does.
- An asynchronous reset mid-frame returns `tx` to 1 immediately and discards all FIFO contents.

## Timing
- All outputs are registered except `ready_out`, which is a compare of the registered count.
- Latency:
  - First start bit appears 1 cycle after the first `baud_tick` seen with count>0.
  - Each bit edge occurs 1 cycle after its `baud_tick`.
- `tx_busy` rises together with the start bit's falling edge. It falls 1 cycle after the final stop-period `baud_tick` when the FIFO is empty.
- Back-to-back frames have zero idle periods between them.

## Structure
- Package `uart_pkg`:
  - `parity_t` enum (NONE, EVEN, ODD, RSVD);
  - `tx_state_t` enum;
  - `MIN_DATA_W`/`MAX_DATA_W` constants, with an elaboration-time range check on `DATA_W` and `FIFO_DEPTH`.
- Sub-module `sync_fifo`, parameterised on width and depth, with push/pop/count. It is reused later by the receiver.
- Serialiser FSM lives in the top level.

## Test plan
- Reset mid-frame: assert `rst_n_in`=0 during DATA → `tx`=1, `tx_busy`=0, `fifo_count_out`=0 within the same cycle, and `ready_out`=1.
- Single byte 0xA5, DATA_W=8, no parity, 1 stop → `tx` sequence per tick 0,1,0,1,0,0,1,0,1,1, then idle. `tx_busy` lasts 10 periods.
- Byte 0x07 with even parity, then odd parity, 2 stop bits:
  - even → parity bit 1, odd → parity bit 0;
  - frame spans 12 periods.
- Burst of 20 pushes with FIFO_DEPTH=16 and no ticks:
  - `ready_out` drops after the 16th accept, and `fifo_count_out`=16;
  - enabling ticks gives 16 back-to-back frames with no idle bit, and `ready_out` returns 1 after the first pop.
- DATA_W=5, byte 0x1F, odd parity → bits 0,1,1,1,1,1,0,1. Upper input bits are ignored.
- Change `parity_mode_in` from none to even during DATA → the current frame has no parity bit, and the next frame carries a parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and limits for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10,
        RSVD = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int MIN_DATA_W     = 5;
    localparam int MAX_DATA_W     = 9;
    localparam int MIN_FIFO_DEPTH = 2;
    localparam int MAX_FIFO_DEPTH = 256;

    function automatic bit cfg_legal(input int data_w, input int depth);
        return (data_w >= MIN_DATA_W) && (data_w <= MAX_DATA_W) &&
               (depth >= MIN_FIFO_DEPTH) && (depth <= MAX_FIFO_DEPTH) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with runtime parity and stop-bit config
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [1:0]        parity_mode_in,
    input  logic              two_stop_in,
    output logic              tx,
    output logic              tx_busy,
    output logic [CNT_W-1:0]  fifo_count_out
);

    localparam int IDX_W = $clog2(DATA_W);

    if (!cfg_legal(DATA_W, FIFO_DEPTH)) begin : g_cfg_check
        $error("uart_tx_fifo: DATA_W or FIFO_DEPTH out of range");
    end

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    parity_t           par_q, par_d;
    logic              two_stop_q, two_stop_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_d, busy_d;
    logic              start_frame;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              par_en;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push      (valid_in),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ready_out = !fifo_full;
    assign par_en    = (par_q == EVEN) || (par_q == ODD);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            par_q      <= NONE;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            idx_q      <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            idx_q      <= idx_d;
            tx         <= tx_d;
            tx_busy    <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        two_stop_d  = two_stop_q;
        stop_cnt_d  = stop_cnt_q;
        idx_d       = idx_q;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (baud_tick && !fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d    = par_en ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Config is sampled only here, so mid-frame changes wait for the next pop.
        if (start_frame) begin
            state_d    = ST_START;
            shreg_d    = fifo_data;
            par_d      = parity_t'(parity_mode_in);
            two_stop_d = two_stop_in;
        end
    end

    assign pop = start_frame;

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[idx_d];
            ST_PARITY: tx_d = (par_d == ODD) ? ~^shreg_d : ^shreg_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    typedef struct packed {
        logic [15:0] bits;
        logic [4:0]  len;
    } frame_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       tick_en, tick_gen, tick_force, tick_at_edge;
    logic       baud_tick;
    logic [7:0] data8;
    logic       valid8, ready8, tx8, busy8;
    logic [1:0] pm8;
    logic       two_stop;
    logic [4:0] cnt8;
    logic [7:0] data5_src;
    logic       valid5, ready5, tx5, busy5;
    logic [1:0] pm5;
    logic [2:0] cnt5;

    int     total = 0;
    int     bad = 0;
    int     tick_div = 0;
    frame_t q8[$];
    frame_t q5[$];
    frame_t cur[2];
    int     pos[2];
    bit     ended[2];
    int     gaps[2];

    assign baud_tick = tick_en ? tick_gen : tick_force;

    always #5 clk_in = ~clk_in;

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16)) u_dut8 (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .baud_tick      (baud_tick),
        .data_in        (data8),
        .valid_in       (valid8),
        .ready_out      (ready8),
        .parity_mode_in (pm8),
        .two_stop_in    (two_stop),
        .tx             (tx8),
        .tx_busy        (busy8),
        .fifo_count_out (cnt8)
    );

    uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(4)) u_dut5 (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .baud_tick      (baud_tick),
        .data_in        (data5_src[4:0]),
        .valid_in       (valid5),
        .ready_out      (ready5),
        .parity_mode_in (pm5),
        .two_stop_in    (two_stop),
        .tx             (tx5),
        .tx_busy        (busy5),
        .fifo_count_out (cnt5)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] b, input int n);
        frame_t f;
        f.bits = b;
        f.len  = 5'(n);
        return f;
    endfunction

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic push8(input logic [7:0] d, input frame_t f, output logic acc);
        data8  = d;
        valid8 = 1'b1;
        acc    = ready8;
        if (acc) q8.push_back(f);
        step();
        valid8 = 1'b0;
    endtask

    task automatic push5(input logic [7:0] d, input frame_t f);
        data5_src = d;
        valid5    = 1'b1;
        if (ready5) q5.push_back(f);
        step();
        valid5 = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (g == 0 && q8.size() == 0 && pos[0] == 0 && !busy8) begin
                done = 1'b1;
                break;
            end
            if (g == 1 && q5.size() == 0 && pos[1] == 0 && !busy5) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("idle_reached_u%0d", g), int'(done), 1);
    endtask

    task automatic wait_pos(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (pos[0] >= n) break;
            step();
        end
        chk("reached_bit_position", int'(pos[0] >= n), 1);
    endtask

    // Baud strobe: periodic when enabled, otherwise driven directly by the stimulus.
    initial begin
        tick_gen     = 1'b0;
        tick_at_edge = 1'b0;
        forever begin
            @(posedge clk_in);
            tick_at_edge = baud_tick;
            #1;
            tick_div = (tick_div + 1) % 4;
            tick_gen = (tick_div == 0);
        end
    end

    // Monitor: one line sample per baud period, one cycle after the tick.
    initial begin
        logic   b, bz;
        int     qn;
        frame_t f;
        pos   = '{0, 0};
        ended = '{1'b0, 1'b0};
        gaps  = '{0, 0};
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                q8.delete();
                q5.delete();
                pos   = '{0, 0};
                ended = '{1'b0, 1'b0};
            end else if (tick_at_edge) begin
                for (int g = 0; g < 2; g++) begin
                    b  = (g == 0) ? tx8 : tx5;
                    bz = (g == 0) ? busy8 : busy5;
                    qn = (g == 0) ? q8.size() : q5.size();
                    if (pos[g] == 0) begin
                        if (b == 1'b0) begin
                            chk($sformatf("expected_frame_pending_u%0d", g), int'(qn != 0), 1);
                            if (qn != 0) begin
                                f = (g == 0) ? q8.pop_front() : q5.pop_front();
                                cur[g] = f;
                                chk($sformatf("start_bit_u%0d", g), int'(b), int'(f.bits[0]));
                                chk($sformatf("busy_at_start_u%0d", g), int'(bz), 1);
                                pos[g] = 1;
                            end
                        end else if (ended[g]) begin
                            if (qn != 0) gaps[g]++;
                            else chk($sformatf("busy_after_frame_u%0d", g), int'(bz), 0);
                        end
                        ended[g] = 1'b0;
                    end else begin
                        chk($sformatf("frame_bit_u%0d_p%0d", g, pos[g]), int'(b),
                            int'(cur[g].bits[pos[g]]));
                        chk($sformatf("busy_in_frame_u%0d", g), int'(bz), 1);
                        pos[g]++;
                        if (pos[g] == int'(cur[g].len)) begin
                            pos[g]   = 0;
                            ended[g] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic [7:0] d;
        int         g0;
        rst_n_in   = 1'b1;
        tick_en    = 1'b0;
        tick_force = 1'b0;
        data8      = '0;
        valid8     = 1'b0;
        pm8        = 2'b00;
        two_stop   = 1'b0;
        data5_src  = '0;
        valid5     = 1'b0;
        pm5        = 2'b00;
        #1 rst_n_in = 1'b0;
        #1;
        chk("reset_tx", int'(tx8), 1);
        chk("reset_busy", int'(busy8), 0);
        chk("reset_ready", int'(ready8), 1);
        chk("reset_count", int'(cnt8), 0);
        chk("reset_tx_u5", int'(tx5), 1);
        chk("reset_ready_u5", int'(ready5), 1);
        chk("reset_count_u5", int'(cnt5), 0);
        repeat (2) step();
        rst_n_in = 1'b1;
        step();
        tick_en = 1'b1;

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        push8(8'hA5, mk({6'b0, 1'b1, 8'hA5, 1'b0}, 10), acc);
        wait_idle(0, 200);

        // 0x07 with two stop bits: even parity bit 1, odd parity bit 0
        two_stop = 1'b1;
        pm8      = 2'b01;
        push8(8'h07, mk({3'b0, 2'b11, 1'b1, 8'h07, 1'b0}, 12), acc);
        wait_idle(0, 200);
        pm8 = 2'b10;
        push8(8'h07, mk({3'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12), acc);
        wait_idle(0, 200);
        two_stop = 1'b0;
        pm8      = 2'b00;

        // Tick coinciding with a push into an empty FIFO must not start a frame
        tick_en    = 1'b0;
        tick_force = 1'b0;
        repeat (2) step();
        data8      = 8'h5A;
        valid8     = 1'b1;
        tick_force = 1'b1;
        q8.push_back(mk({6'b0, 1'b1, 8'h5A, 1'b0}, 10));
        step();
        valid8     = 1'b0;
        tick_force = 1'b0;
        chk("same_cycle_count", int'(cnt8), 1);
        chk("same_cycle_tx_idle", int'(tx8), 1);
        chk("same_cycle_busy_low", int'(busy8), 0);
        step();
        chk("no_tick_tx_idle", int'(tx8), 1);
        tick_force = 1'b1;
        step();
        tick_force = 1'b0;
        chk("next_tick_start_bit", int'(tx8), 0);
        chk("next_tick_busy", int'(busy8), 1);
        chk("next_tick_popped", int'(cnt8), 0);
        tick_en = 1'b1;
        wait_idle(0, 200);

        // Parity switched to even mid-frame: only the following frame carries parity
        push8(8'h3C, mk({6'b0, 1'b1, 8'h3C, 1'b0}, 10), acc);
        push8(8'h81, mk({5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11), acc);
        wait_pos(3, 100);
        pm8 = 2'b01;
        wait_idle(0, 300);
        pm8 = 2'b00;

        // Five-bit instance, odd parity: 0,1,1,1,1,1,0,1
        pm5 = 2'b10;
        push5(8'hFF, mk({8'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 8));
        wait_idle(1, 200);

        // Burst of 20 pushes into a 16-deep FIFO with the baud strobe held off
        tick_en    = 1'b0;
        tick_force = 1'b0;
        step();
        g0 = gaps[0];
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 37 + 5);
            push8(d, mk({6'b0, 1'b1, d, 1'b0}, 10), acc);
            chk($sformatf("burst_accept_%0d", i), int'(acc), int'(i < 16));
        end
        chk("burst_count_full", int'(cnt8), 16);
        chk("burst_ready_low", int'(ready8), 0);
        tick_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (cnt8 != 5'd16) break;
            step();
        end
        chk("burst_first_pop_count", int'(cnt8), 15);
        chk("burst_ready_after_pop", int'(ready8), 1);
        wait_idle(0, 16 * 40 + 200);
        chk("burst_idle_gaps", gaps[0] - g0, 0);

        // Asynchronous reset in the middle of a data bit
        push8(8'hC3, mk({6'b0, 1'b1, 8'hC3, 1'b0}, 10), acc);
        push8(8'h3C, mk({6'b0, 1'b1, 8'h3C, 1'b0}, 10), acc);
        wait_pos(4, 100);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("midframe_reset_tx", int'(tx8), 1);
        chk("midframe_reset_busy", int'(busy8), 0);
        chk("midframe_reset_count", int'(cnt8), 0);
        chk("midframe_reset_ready", int'(ready8), 1);
        repeat (2) step();
        rst_n_in = 1'b1;
        step();
        push8(8'h96, mk({6'b0, 1'b1, 8'h96, 1'b0}, 10), acc);
        wait_idle(0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
